// File: rtl/fir_pkg.sv
// Shared sizes and types for the 64-tap FIR MAC sequencer.
// The external MAC and this block both run on the same free-running 6-bit phase.
package fir_pkg;
  localparam int TAPS    = 64;
  localparam int DW      = 16;
  localparam int ACC_W   = 32;
  localparam int PHASE_W = 6;

  typedef enum logic {
    FRM_IDLE   = 1'b0,
    FRM_ACTIVE = 1'b1
  } frame_state_t;
endpackage

// File: rtl/fir_delay_line.sv
// Circular 64x16 sample store: push writes at wptr+1 and advances wptr.
// Tap read is combinational: o_tap_data = dl[(wptr - i_tap) mod 64].
module fir_delay_line
  import fir_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [DW-1:0]      i_sample,
  input  logic [PHASE_W-1:0] i_tap,
  output logic [DW-1:0]      o_tap_data
);

  logic [DW-1:0]      r_dl [TAPS];
  logic [PHASE_W-1:0] r_wptr;
  logic [PHASE_W-1:0] w_wptr_nxt;
  logic [PHASE_W-1:0] w_rd_idx;

  assign w_wptr_nxt = r_wptr + 1'b1;
  // Modulo-64 wrap falls out of the 6-bit subtraction.
  assign w_rd_idx   = r_wptr - i_tap;
  assign o_tap_data = r_dl[w_rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      for (int i = 0; i < TAPS; i++) begin
        r_dl[i] <= '0;
      end
    end else if (i_push) begin
      r_dl[w_wptr_nxt] <= i_sample;
      r_wptr           <= w_wptr_nxt;
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Feeds an external MAC one tap per cycle over 64-cycle frames and captures its result.
// One sample per frame; a sample arriving mid-frame waits in a 1-entry holding register.
module fir_mac_sequencer
  import fir_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               cfg_we,
  input  logic [PHASE_W-1:0] cfg_addr,
  input  logic [DW-1:0]      cfg_data,
  output logic               cfg_busy,
  output logic               cfg_err,
  output logic [DW-1:0]      mac_x,
  output logic [DW-1:0]      mac_coeff,
  input  logic [ACC_W-1:0]   mac_y,
  input  logic               mac_tick,
  output logic [ACC_W-1:0]   y_data,
  output logic               y_valid,
  input  logic               y_ready,
  output logic               y_ovf
);

  frame_state_t       r_state;
  frame_state_t       w_state_nxt;
  logic               r_prev_active;
  logic [PHASE_W-1:0] r_phase;
  logic               r_pending;
  logic [DW-1:0]      r_hold;
  logic [DW-1:0]      r_coef [TAPS];
  logic               r_cfg_err;
  logic [ACC_W-1:0]   r_y_data;
  logic               r_y_valid;
  logic               r_y_ovf;

  logic               w_frame_end;
  logic               w_active;
  logic               w_accept;
  logic               w_push;
  logic               w_load;
  logic [DW-1:0]      w_tap_data;

  assign w_frame_end = (r_phase == PHASE_W'(TAPS - 1));
  assign w_active    = (r_state == FRM_ACTIVE);
  assign w_accept    = s_valid & s_ready;
  assign w_push      = w_frame_end & r_pending;
  // The MAC ticks in the first cycle of the next frame, so qualify with the frame it finished.
  assign w_load      = mac_tick & r_prev_active;

  assign s_ready   = ~r_pending;
  assign cfg_busy  = w_active;
  assign cfg_err   = r_cfg_err;
  assign mac_x     = w_active ? w_tap_data : '0;
  assign mac_coeff = w_active ? r_coef[r_phase] : '0;
  assign y_data    = r_y_data;
  assign y_valid   = r_y_valid;
  assign y_ovf     = r_y_ovf;

  fir_delay_line u_delay_line (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_sample   (r_hold),
    .i_tap      (r_phase),
    .o_tap_data (w_tap_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_frame_end) begin
      w_state_nxt = r_pending ? FRM_ACTIVE : FRM_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= FRM_IDLE;
      r_prev_active <= 1'b0;
      r_phase       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= r_phase + 1'b1;
      if (w_frame_end) begin
        r_prev_active <= w_active;
      end
    end
  end

  // A sample taken during phase 63 sees r_pending low here, so it waits a full frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_hold    <= '0;
    end else if (w_push) begin
      r_pending <= 1'b0;
    end else if (w_accept) begin
      r_pending <= 1'b1;
      r_hold    <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_err <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        r_coef[i] <= '0;
      end
    end else if (cfg_we) begin
      if (w_active) begin
        r_cfg_err <= 1'b1;
      end else begin
        r_coef[cfg_addr] <= cfg_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_data  <= '0;
      r_y_valid <= 1'b0;
      r_y_ovf   <= 1'b0;
    end else if (w_load) begin
      r_y_data  <= mac_y;
      r_y_valid <= 1'b1;
      if (r_y_valid && !y_ready) begin
        r_y_ovf <= 1'b1;
      end
    end else if (r_y_valid && y_ready) begin
      r_y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench: a behavioural MAC closes the loop, expected y values are hand-computed.
// Results are popped and compared by a monitor on every y handshake.
module tb_fir_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_busy;
  logic        cfg_err;
  logic [15:0] mac_x;
  logic [15:0] mac_coeff;
  logic [31:0] mac_y;
  logic        mac_tick;
  logic [31:0] y_data;
  logic        y_valid;
  logic        y_ready;
  logic        y_ovf;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_mac_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_busy  (cfg_busy),
    .cfg_err   (cfg_err),
    .mac_x     (mac_x),
    .mac_coeff (mac_coeff),
    .mac_y     (mac_y),
    .mac_tick  (mac_tick),
    .y_data    (y_data),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .y_ovf     (y_ovf)
  );

  // Behavioural MAC: accumulates phases 0..63, presents the sum with a tick in the next phase 0.
  logic [5:0]         m_phase;
  logic signed [31:0] m_acc;
  logic signed [31:0] m_xs;
  logic signed [31:0] m_cs;
  logic signed [31:0] m_prod;
  assign m_xs   = {{16{mac_x[15]}}, mac_x};
  assign m_cs   = {{16{mac_coeff[15]}}, mac_coeff};
  assign m_prod = m_xs * m_cs;

  always @(posedge clk) begin
    if (rst) begin
      m_phase  <= '0;
      m_acc    <= '0;
      mac_y    <= '0;
      mac_tick <= 1'b0;
    end else begin
      m_phase  <= m_phase + 6'd1;
      mac_tick <= (m_phase == 6'd63);
      if (m_phase == 6'd63) begin
        mac_y <= m_acc + m_prod;
        m_acc <= '0;
      end else begin
        m_acc <= m_acc + m_prod;
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (!rst && y_valid && y_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL y_extra got %h required none", y_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (y_data !== mon_exp) begin
          n_errors++;
          $display("FAIL y_data got %h required %h", y_data, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s got timeout required event", name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_coef(input logic [5:0] a, input logic [15:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic program_ramp();
    for (int k = 0; k < 64; k++) write_coef(6'(k), 16'(k + 1));
  endtask

  // Entered and left at a negedge; s_valid stays high so back-to-back calls stream continuously.
  task automatic stream(input logic [15:0] d, output int acc_c);
    int w;
    w       = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) timeout("s_ready_wait");
    @(posedge clk);
    #1;
    acc_c = cyc;
    chk("s_ready_pending", {31'b0, s_ready}, 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_phase(input logic [5:0] p);
    int w;
    w = 0;
    while (m_phase != p && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) timeout("phase_wait");
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 6000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 6000) timeout("drain");
    repeat (70) @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

  initial begin
    int acc [5];
    int a;
    int w;
    int nvalid;
    rst = 1'b1; s_data = '0; s_valid = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_data = '0; y_ready = 1'b1;
    do_reset();

    chk("rst_s_ready",   {31'b0, s_ready},  32'd1);
    chk("rst_cfg_busy",  {31'b0, cfg_busy}, 32'd0);
    chk("rst_cfg_err",   {31'b0, cfg_err},  32'd0);
    chk("rst_mac_x",     {16'b0, mac_x},    32'd0);
    chk("rst_mac_coeff", {16'b0, mac_coeff}, 32'd0);
    chk("rst_y_data",    y_data,            32'd0);
    chk("rst_y_valid",   {31'b0, y_valid},  32'd0);
    chk("rst_y_ovf",     {31'b0, y_ovf},    32'd0);

    // Impulse through a ramp filter: 1,2,...,64 then 0.
    program_ramp();
    for (int k = 1; k <= 64; k++) exp_q.push_back(32'(k));
    exp_q.push_back(32'd0);
    for (int i = 0; i < 65; i++) begin
      stream((i == 0) ? 16'd1 : 16'd0, a);
      if (i < 5) acc[i] = a;
    end
    s_valid = 1'b0;
    chk("accept_gap_1", 32'(acc[2] - acc[1]), 32'd64);
    chk("accept_gap_2", 32'(acc[3] - acc[2]), 32'd64);
    chk("accept_gap_3", 32'(acc[4] - acc[3]), 32'd64);
    drain();
    chk("ovf_after_stream", {31'b0, y_ovf}, 32'd0);

    // Sample offered in phase 63 waits a whole frame; worst-case latency 129.
    exp_q.push_back(32'd5);
    wait_phase(6'd63);
    s_data = 16'd5; s_valid = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
    chk("p63_accepted",  {31'b0, s_ready},  32'd0);
    chk("p63_idle_busy", {31'b0, cfg_busy}, 32'd0);
    chk("p63_idle_x",    {16'b0, mac_x},    32'd0);
    @(negedge clk);
    s_valid = 1'b0;
    w = 0;
    while (!cfg_busy && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) timeout("busy_wait");
    chk("p0_mac_x",     {16'b0, mac_x},     32'd5);
    chk("p0_mac_coeff", {16'b0, mac_coeff}, 32'd1);
    w = 0;
    while (!y_valid && w < 200) begin @(negedge clk); w++; end
    if (w >= 200) timeout("y_valid_wait");
    chk("latency", 32'(cyc - a), 32'd129);
    drain();

    // Max positive coefficient times -1; cfg write during the frame is rejected.
    do_reset();
    write_coef(6'd0, 16'h7FFF);
    exp_q.push_back(32'hFFFF8001);
    stream(16'hFFFF, a);
    s_valid = 1'b0;
    w = 0;
    while (!cfg_busy && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) timeout("busy_wait2");
    write_coef(6'd0, 16'h0001);
    chk("cfg_err_set", {31'b0, cfg_err}, 32'd1);
    exp_q.push_back(32'h0000FFFE);
    stream(16'd2, a);
    s_valid = 1'b0;
    drain();
    chk("cfg_err_sticky", {31'b0, cfg_err}, 32'd1);

    // Unread result overwritten by the next frame.
    y_ready = 1'b0;
    exp_q.push_back(32'h00017FFD);
    stream(16'd1, a);
    stream(16'd3, a);
    s_valid = 1'b0;
    w = 0;
    while (!y_ovf && w < 400) begin @(negedge clk); w++; end
    if (w >= 400) timeout("ovf_wait");
    chk("ovf_y_valid", {31'b0, y_valid}, 32'd1);
    chk("ovf_y_data",  y_data,           32'h00017FFD);
    y_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ovf_sticky",  {31'b0, y_ovf},   32'd1);
    chk("ovf_y_clear", {31'b0, y_valid}, 32'd0);
    drain();

    // Reset at phase 30 of an active frame abandons it.
    do_reset();
    chk("rst2_y_ovf",   {31'b0, y_ovf},   32'd0);
    chk("rst2_cfg_err", {31'b0, cfg_err}, 32'd0);
    program_ramp();
    exp_q.push_back(32'd7);
    stream(16'd7, a);
    stream(16'd8, a);
    s_valid = 1'b0;
    w = 0;
    while (!y_valid && w < 300) begin @(negedge clk); w++; end
    if (w >= 300) timeout("y7_wait");
    wait_phase(6'd30);
    chk("mid_busy", {31'b0, cfg_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_s_ready", {31'b0, s_ready},  32'd1);
    chk("mid_busy_0",  {31'b0, cfg_busy}, 32'd0);
    chk("mid_mac_x",   {16'b0, mac_x},    32'd0);
    nvalid = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (y_valid) nvalid++;
    end
    chk("mid_no_output", 32'(nvalid), 32'd0);
    program_ramp();
    exp_q.push_back(32'd9);
    stream(16'd9, a);
    s_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 clk  in  1  clock; all logic rising-edge.
REQ-002 rst  in  1  reset, synchronous, active-high; shared with the MAC instance so both phase counters start together.
REQ-003 s_data  in  16  input sample, signed two's complement.
REQ-004 s_valid  in  1  sample offered.
REQ-005 s_ready  out  1  sample accepted on s_valid & s_ready.
REQ-006 cfg_we  in  1  coefficient write strobe.
REQ-007 cfg_addr  in  6  coefficient index 0..63.
REQ-008 cfg_data  in  16  coefficient value, signed.
REQ-009 cfg_busy  out  1  high while a frame is active; cfg writes ignored.
REQ-010 cfg_err  out  1  sticky; set by any cfg_we while cfg_busy.
REQ-011 mac_x  out  16  sample operand to MAC.
REQ-012 mac_coeff  out  16  coefficient operand to MAC.
REQ-013 mac_y  in  32  MAC result, signed.
REQ-014 mac_tick  in  1  MAC result strobe, one cycle per 64-cycle frame.
REQ-015 y_data  out  32  filter output, signed.
REQ-016 y_valid  out  1  y_data holds an unread result.
REQ-017 y_ready  in  1  consumer accepts on y_valid & y_ready.
REQ-018 y_ovf  out  1  sticky; set when an unread result is overwritten.

Function
REQ-019 A 6-bit phase counter shall reset to 0 and increment every cycle unconditionally, wrapping 63->0; phase p is consumed by the MAC at the edge ending that cycle.
REQ-020 A 1-entry sample holding register shall exist; s_ready = !pending.
REQ-021 At the edge ending phase 63: if pending, the sample shall be written to the delay line at wptr+1, wptr shall advance, pending shall clear and the next frame shall be active; otherwise the next frame shall be inactive.
REQ-022 A sample accepted in the phase-63 cycle shall be held for the following frame boundary, not written in the same cycle.
REQ-023 During an active frame in phase p: mac_x = dl[(wptr - p) mod 64], mac_coeff = coef[p] (combinational from registers).
REQ-024 During an inactive frame mac_x and mac_coeff shall be 0.
REQ-025 cfg_busy shall equal the active-frame flag; cfg writes when !cfg_busy shall update coef[cfg_addr] at that edge.
REQ-026 On mac_tick, if the frame just completed was active, mac_y shall load y_data and set y_valid; results of inactive frames shall be discarded.
REQ-027 y_valid shall clear on y_valid & y_ready unless a new result loads in the same cycle (load wins, y_valid stays 1, y_ovf not set).
REQ-028 A load while y_valid & !y_ready shall overwrite y_data and set y_ovf.
REQ-029 Latency sample-accept to y_valid: at most 129 cycles; throughput one sample per 64 cycles.

Reset
REQ-030 On rst: phase=0, wptr=0, pending=0, active=0, all delay-line and coefficient entries=0.
REQ-031 On rst: s_ready=1 after reset, cfg_busy=0, cfg_err=0, mac_x=0, mac_coeff=0, y_data=0, y_valid=0, y_ovf=0.
REQ-032 Reset mid-frame shall abandon the frame with no output and no held sample.

Structure
REQ-033 Package fir_pkg shall hold TAPS=64, DW=16, ACC_W=32, PHASE_W=6.
REQ-034 The circular sample store (64x16, wptr, tap read port) shall be sub-module fir_delay_line.
REQ-035 Target 150-300 lines RTL.

Verification
REQ-036 coef[k]=k+1; samples 1,0,0,... -> successive y_data 1,2,3,...,64, then 0.
REQ-037 coef[0]=0x7FFF, rest 0; sample 0xFFFF -> y_data 0xFFFF8001.
REQ-038 y_ready=0, two active frames -> y_data = second result, y_ovf=1.
REQ-039 cfg_we during active frame -> coef unchanged, cfg_err=1 until rst.
REQ-040 rst at phase 30 of active frame -> no y_valid; next sample's result equals fresh-reset response.
REQ-041 s_valid held high continuously -> one accept per 64 cycles, s_ready low while pending.
